// File: rtl/pwm_driver_motoare_pkg.sv
// Shared definitions for the motor PWM driver: direction codes, BCD limits,
// channel state encoding and small BCD helpers.
package pwm_driver_motoare_pkg;

    localparam logic [1:0]  DIR_STOP = 2'b00;
    localparam logic [1:0]  DIR_FWD  = 2'b10;
    localparam logic [1:0]  DIR_REV  = 2'b01;

    localparam logic [11:0] BCD_MAX  = 12'h999;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } canal_state_t;

    // Three-digit BCD increment with per-digit carry, wrapping 999 -> 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] value);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = value[3:0];
        d1 = value[7:4];
        d2 = value[11:8];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                if (d2 == 4'd9) begin
                    d2 = 4'd0;
                end else begin
                    d2 = d2 + 4'd1;
                end
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    function automatic logic [11:0] bcd_sanitise(input logic [11:0] value);
        if ((value[3:0] > 4'd9) || (value[7:4] > 4'd9) || (value[11:8] > 4'd9)) begin
            return BCD_MAX;
        end
        return value;
    endfunction

    // The illegal code 11 is treated as a stop request.
    function automatic logic [1:0] dir_sanitise(input logic [1:0] dir);
        case (dir)
            DIR_FWD, DIR_REV: return dir;
            default:          return DIR_STOP;
        endcase
    endfunction

endpackage

// File: rtl/pwm_driver_motoare_canal.sv
// One H-bridge channel: command latching on period boundaries, reversal
// dead time (RUN/DEAD FSM) and the registered PWM comparator.
import pwm_driver_motoare_pkg::*;

module pwm_canal #(
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_boundary,
    input  logic [11:0] i_count,
    input  logic [1:0]  i_dir,
    input  logic [11:0] i_factor,
    output logic [1:0]  o_dir,
    output logic        o_pwm
);

    localparam int             DW        = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_PERIODS - 1);

    canal_state_t  r_state;
    canal_state_t  w_state_next;
    logic [1:0]    r_dir_lat;
    logic [1:0]    w_dir_next;
    logic [1:0]    w_dir_new;
    logic [11:0]   r_duty_lat;
    logic [11:0]   w_duty_next;
    logic [11:0]   w_factor_san;
    logic [DW-1:0] r_dead_cnt;
    logic [DW-1:0] w_dead_next;
    logic          r_pwm;

    assign w_dir_new    = dir_sanitise(i_dir);
    assign w_factor_san = bcd_sanitise(i_factor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Commands are only looked at on a boundary; in between everything holds.
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir_lat;
        w_duty_next  = r_duty_lat;
        w_dead_next  = r_dead_cnt;
        if (i_boundary) begin
            case (r_state)
                ST_RUN: begin
                    if (w_dir_new == r_dir_lat) begin
                        w_duty_next = w_factor_san;
                    end else if ((w_dir_new == DIR_STOP) || (r_dir_lat == DIR_STOP)) begin
                        w_dir_next  = w_dir_new;
                        w_duty_next = w_factor_san;
                    end else begin
                        w_state_next = ST_DEAD;
                        w_dir_next   = DIR_STOP;
                        w_dead_next  = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    if (r_dead_cnt != '0) begin
                        w_dead_next = r_dead_cnt - 1'b1;
                    end else begin
                        w_state_next = ST_RUN;
                        w_dir_next   = w_dir_new;
                        w_duty_next  = w_factor_san;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_lat  <= DIR_STOP;
            r_duty_lat <= '0;
            r_dead_cnt <= '0;
        end else begin
            r_dir_lat  <= w_dir_next;
            r_duty_lat <= w_duty_next;
            r_dead_cnt <= w_dead_next;
        end
    end

    // Count 999 never satisfies count < duty, so the output is always low on
    // the edge that applies a new command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_state == ST_RUN) && (r_dir_lat != DIR_STOP) && (i_count < r_duty_lat);
        end
    end

    assign o_dir = r_dir_lat;
    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_driver_motoare.sv
// Two-channel H-bridge PWM driver: shared prescaler and BCD period counter,
// period boundary strobe, and one pwm_canal per motor driver.
import pwm_driver_motoare_pkg::*;

module pwm_driver_motoare #(
    parameter int PRESC        = 50,
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic [1:0]  dir_outA,
    output logic [1:0]  dir_outB,
    output logic        pwm_A,
    output logic        pwm_B,
    output logic        perioada
);

    localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] r_presc;
    logic [11:0]   r_count;
    logic          r_perioada;
    logic          w_tick;
    logic          w_boundary;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_boundary = w_tick && (r_count == BCD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_perioada <= 1'b0;
        end else begin
            r_perioada <= w_boundary;
            if (w_tick) begin
                r_count <= bcd_inc(r_count);
            end
        end
    end

    assign perioada = r_perioada;

    pwm_canal #(
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_canal_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_boundary (w_boundary),
        .i_count    (r_count),
        .i_dir      (directie_driverA),
        .i_factor   (factor_dc_driverA),
        .o_dir      (dir_outA),
        .o_pwm      (pwm_A)
    );

    pwm_canal #(
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_canal_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_boundary (w_boundary),
        .i_count    (r_count),
        .i_dir      (directie_driverB),
        .i_factor   (factor_dc_driverB),
        .o_dir      (dir_outB),
        .o_pwm      (pwm_B)
    );

endmodule
